// File: rtl/axis_master.sv
// axis_master: single-beat AXI4-Stream master; defining AXIS_M_TKEEP_EN adds the tkeep output
module axis_master #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    send,
    input  logic                    tready,
    output logic                    tvalid,
    output logic                    tlast,
    output logic [DATA_WIDTH-1:0]   tdata,
`ifdef AXIS_M_TKEEP_EN
    output logic [DATA_WIDTH/8-1:0] tkeep,
`endif
    output logic                    finish
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARM   = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] VALID = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  send_q, pending_q, pending_d;
    logic                  tvalid_q, tvalid_d, finish_q, finish_d;
    logic [DATA_WIDTH-1:0] data_buf_q, data_buf_d, tdata_q, tdata_d;
    logic                  send_edge;

    always_comb begin
        send_edge  = send & ~send_q;
        // a second request while one is already queued is dropped, keeping the queued word
        data_buf_d = (send_edge && !(pending_q && state_q != IDLE)) ? data : data_buf_q;
        pending_d  = (state_q == IDLE) ? 1'b0 : (pending_q | send_edge);
        state_d    = state_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        finish_d   = 1'b0;
        case (state_q)
            IDLE:    state_d = (send_edge || pending_q) ? ARM : IDLE;
            ARM:     state_d = LOAD;
            LOAD: begin
                state_d  = VALID;
                tdata_d  = data_buf_q;
                tvalid_d = 1'b1;
            end
            default: if (tready) begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
                finish_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            send_q     <= 1'b0;
            pending_q  <= 1'b0;
            data_buf_q <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            send_q     <= send;
            pending_q  <= pending_d;
            data_buf_q <= data_buf_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            finish_q   <= finish_d;
        end
    end

    assign tvalid = tvalid_q;
    assign tlast  = tvalid_q;
    assign tdata  = tdata_q;
    assign finish = finish_q;
`ifdef AXIS_M_TKEEP_EN
    assign tkeep  = {(DATA_WIDTH/8){tvalid_q}};
`endif
endmodule

// File: tb/tb_axis_master.sv
// tb_axis_master: directed self-checking bench for axis_master
module tb_axis_master;
    logic        aclk = 1'b0;
    logic        areset, send, tready, tvalid, tlast, finish;
    logic [31:0] data, tdata;
`ifdef AXIS_M_TKEEP_EN
    logic [3:0]  tkeep;
`endif
    int          errors = 0;
    int          checks = 0;
    int          fin_cnt;
    logic [31:0] fin_data;

    axis_master #(.DATA_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset), .data(data), .send(send), .tready(tready),
        .tvalid(tvalid), .tlast(tlast), .tdata(tdata),
`ifdef AXIS_M_TKEEP_EN
        .tkeep(tkeep),
`endif
        .finish(finish)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic out_is(input string tag, input logic v, input logic f, input logic [31:0] d);
        check({tag, ".tvalid"}, 64'(tvalid), 64'(v));
        check({tag, ".tlast"}, 64'(tlast), 64'(v));
        check({tag, ".finish"}, 64'(finish), 64'(f));
        check({tag, ".tdata"}, 64'(tdata), 64'(d));
`ifdef AXIS_M_TKEEP_EN
        check({tag, ".tkeep"}, 64'(tkeep), v ? 64'hf : 64'h0);
`endif
    endtask

    initial begin
        areset = 1'b1; send = 1'b0; tready = 1'b0; data = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            out_is("reset", 1'b0, 1'b0, 32'h0);
        end
        areset = 1'b0;
        tick();

        // single word, then a new edge in the handshake clock
        send = 1'b1; data = 32'haaaa_bbbb; tready = 1'b1;
        tick();
        send = 1'b0; data = $urandom; tready = 1'b0;
        tick();
        out_is("single.load", 1'b0, 1'b0, 32'h0);
        tick();
        out_is("single.valid", 1'b1, 1'b0, 32'haaaa_bbbb);
        tready = 1'b1; send = 1'b1; data = 32'hcccc_dddd;
        tick();
        out_is("b2b.finish1", 1'b0, 1'b1, 32'haaaa_bbbb);
        send = 1'b0; tready = 1'b0; data = $urandom;
        tick();
        out_is("b2b.arm", 1'b0, 1'b0, 32'haaaa_bbbb);
        tick();
        out_is("b2b.load", 1'b0, 1'b0, 32'haaaa_bbbb);
        tick();
        out_is("b2b.valid2", 1'b1, 1'b0, 32'hcccc_dddd);

        // backpressure on word 2
        for (int i = 0; i < 10; i++) begin
            tick();
            out_is("bp.hold", 1'b1, 1'b0, 32'hcccc_dddd);
        end
        tready = 1'b1;
        tick();
        out_is("bp.accept", 1'b0, 1'b1, 32'hcccc_dddd);
        tready = 1'b0;
        tick();
        out_is("bp.after", 1'b0, 1'b0, 32'hcccc_dddd);

        // level hold produces exactly one transfer
        send = 1'b1; data = 32'h1234_5678; tready = 1'b1;
        fin_cnt = 0; fin_data = '0;
        for (int i = 0; i < 25; i++) begin
            if (i == 20) send = 1'b0;
            tick();
            if (finish) begin
                fin_cnt++;
                fin_data = tdata;
            end
        end
        check("level.finishes", 64'(fin_cnt), 64'd1);
        check("level.tdata", 64'(fin_data), 64'h1234_5678);
        tready = 1'b0;

        // second edge while one is pending is dropped
        send = 1'b1; data = 32'h1111_1111;
        tick();
        send = 1'b0;
        tick();
        send = 1'b1; data = 32'h2222_2222;
        tick();
        out_is("drop.valid1", 1'b1, 1'b0, 32'h1111_1111);
        send = 1'b0;
        tick();
        send = 1'b1; data = 32'h3333_3333;
        tick();
        send = 1'b0;
        out_is("drop.hold1", 1'b1, 1'b0, 32'h1111_1111);
        tready = 1'b1;
        tick();
        out_is("drop.finish1", 1'b0, 1'b1, 32'h1111_1111);
        tready = 1'b0;
        tick();
        tick();
        tick();
        out_is("drop.valid2", 1'b1, 1'b0, 32'h2222_2222);
        tready = 1'b1;
        tick();
        out_is("drop.finish2", 1'b0, 1'b1, 32'h2222_2222);
        tready = 1'b0;
        tick();
        out_is("drop.idle", 1'b0, 1'b0, 32'h2222_2222);

        // reset while VALID aborts without finish
        send = 1'b1; data = 32'hdead_beef;
        tick();
        send = 1'b0;
        tick();
        tick();
        out_is("midrst.valid", 1'b1, 1'b0, 32'hdead_beef);
        areset = 1'b1; tready = 1'b1;
        tick();
        out_is("midrst.reset", 1'b0, 1'b0, 32'h0);
        areset = 1'b0;
        tick();
        out_is("midrst.after", 1'b0, 1'b0, 32'h0);
        send = 1'b1; data = 32'h0bad_f00d;
        tick();
        send = 1'b0;
        tick();
        tick();
        out_is("midrst.fresh", 1'b1, 1'b0, 32'h0bad_f00d);
        tick();
        out_is("midrst.finish", 1'b0, 1'b1, 32'h0bad_f00d);
        tick();
        out_is("midrst.done", 1'b0, 1'b0, 32'h0bad_f00d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
